klein_iter_core: RTL and testbench

//  Iterative, one-round-per-cycle KLEIN block cipher core: 64-bit block, key of 64/80/96 bits.

---
 rtl/klein_pkg.sv | 117 +++++++++++
 rtl/klein_round_datapath.sv | 22 ++
 rtl/klein_iter_core.sv | 146 ++++++++++++++
 tb/tb_klein_iter_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/klein_pkg.sv
// KLEIN shared definitions: S-box, nibble mixing, key schedule steps and FSM states.
package klein_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEXP  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Key schedule helpers work on a right-aligned key in a fixed-width container.
  localparam int KW_MAX = 96;

  function automatic int nr_of(input int key_w);
    if (key_w == 64)      return 12;
    else if (key_w == 80) return 16;
    else                  return 20;
  endfunction

  // KLEIN S-box is an involution, so it serves both directions.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h7;  4'h1: return 4'h4;  4'h2: return 4'ha;  4'h3: return 4'h9;
      4'h4: return 4'h1;  4'h5: return 4'hf;  4'h6: return 4'hb;  4'h7: return 4'h0;
      4'h8: return 4'hc;  4'h9: return 4'h3;  4'ha: return 4'h2;  4'hb: return 4'h6;
      4'hc: return 4'h8;  4'hd: return 4'he;  4'he: return 4'hd;  default: return 4'h5;
    endcase
  endfunction

  function automatic logic [63:0] sub_nibbles(input logic [63:0] s);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox(s[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant.
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {gm(b0, 4'd2) ^ gm(b1, 4'd3) ^ b2 ^ b3,
            b0 ^ gm(b1, 4'd2) ^ gm(b2, 4'd3) ^ b3,
            b0 ^ b1 ^ gm(b2, 4'd2) ^ gm(b3, 4'd3),
            gm(b0, 4'd3) ^ b1 ^ b2 ^ gm(b3, 4'd2)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {gm(b0, 4'd14) ^ gm(b1, 4'd11) ^ gm(b2, 4'd13) ^ gm(b3, 4'd9),
            gm(b0, 4'd9)  ^ gm(b1, 4'd14) ^ gm(b2, 4'd11) ^ gm(b3, 4'd13),
            gm(b0, 4'd13) ^ gm(b1, 4'd9)  ^ gm(b2, 4'd14) ^ gm(b3, 4'd11),
            gm(b0, 4'd11) ^ gm(b1, 4'd13) ^ gm(b2, 4'd9)  ^ gm(b3, 4'd14)};
  endfunction

  function automatic logic [63:0] mix_nibbles(input logic [63:0] s);
    return {mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [63:0] inv_mix_nibbles(input logic [63:0] s);
    return {inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
  endfunction

  // S-box the 16 bits starting at bit offset off (bytes 2 and 3 of a half).
  function automatic logic [KW_MAX-1:0] sub_bytes23(input logic [KW_MAX-1:0] b, input int off);
    logic [15:0]       t;
    logic [KW_MAX-1:0] m;
    t = 16'(b >> off);
    t = {sbox(t[15:12]), sbox(t[11:8]), sbox(t[7:4]), sbox(t[3:0])};
    m = {80'd0, 16'hffff} << off;
    return (b & ~m) | ({80'd0, t} << off);
  endfunction

  // sk_i -> sk_{i+1} for a key of key_w bits right-aligned in k.
  function automatic logic [KW_MAX-1:0] key_step(input logic [KW_MAX-1:0] k,
                                                 input logic [7:0] i, input int key_w);
    int                h;
    logic [KW_MAX-1:0] mask, a, b, a1, b1, a2, b2;
    h    = key_w / 2;
    mask = (96'd1 << h) - 96'd1;
    a    = (k >> h) & mask;
    b    = k & mask;
    a1   = ((a << 8) | (a >> (h - 8))) & mask;
    b1   = ((b << 8) | (b >> (h - 8))) & mask;
    a2   = b1 ^ ({88'd0, i} << (h - 24));
    b2   = sub_bytes23(a1 ^ b1, h - 24);
    return (a2 << h) | b2;
  endfunction

  // sk_{i+1} -> sk_i, exact inverse of key_step.
  function automatic logic [KW_MAX-1:0] inv_key_step(input logic [KW_MAX-1:0] k,
                                                     input logic [7:0] i, input int key_w);
    int                h;
    logic [KW_MAX-1:0] mask, a, b, a1, b1, a2, b2;
    h    = key_w / 2;
    mask = (96'd1 << h) - 96'd1;
    a2   = ((k >> h) & mask) ^ ({88'd0, i} << (h - 24));
    b2   = sub_bytes23(k & mask, h - 24);
    b1   = a2;
    a1   = b2 ^ a2;
    a    = ((a1 >> 8) | (a1 << (h - 8))) & mask;
    b    = ((b1 >> 8) | (b1 << (h - 8))) & mask;
    return (a << h) | b;
  endfunction

endpackage

// File: rtl/klein_round_datapath.sv
// One KLEIN round, forward or inverse, purely combinational.
module klein_round_datapath
  import klein_pkg::*;
(
  input  logic        mode,
  input  logic [63:0] state_in,
  input  logic [63:0] rk,
  output logic [63:0] state_out
);

  logic [63:0] enc_sub, enc_rot, dec_mix, dec_rot;

  // Forward: ARK, Sub, rotl16, Mix. Inverse: InvMix, rotr16, Sub, ARK.
  always_comb begin
    enc_sub   = sub_nibbles(state_in ^ rk);
    enc_rot   = {enc_sub[47:0], enc_sub[63:48]};
    dec_mix   = inv_mix_nibbles(state_in);
    dec_rot   = {dec_mix[15:0], dec_mix[63:16]};
    state_out = mode ? (sub_nibbles(dec_rot) ^ rk) : mix_nibbles(enc_rot);
  end

endmodule

// File: rtl/klein_iter_core.sv
// Iterative KLEIN core: one round per cycle, key walked on chip, valid/ready on both sides.
module klein_iter_core
  import klein_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [63:0]      data_in,
  input  logic [KEY_W-1:0] key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      data_out,
  output logic             busy
);

  localparam int         NR   = nr_of(KEY_W);
  localparam logic [4:0] NR_C = 5'(NR);

  if (!(KEY_W == 64 || KEY_W == 80 || KEY_W == 96)) begin : g_bad_key_w
    $error("klein_iter_core: KEY_W must be 64, 80 or 96");
  end

  state_e           state_q, state_d;
  logic [4:0]       rnd_q, rnd_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [63:0]      data_q, data_d;
  logic             mode_q, mode_d;
  logic [63:0]      data_out_q, data_out_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [KEY_W-1:0] fwd_key, inv_key;
  logic [63:0]      rk, rnd_out;

  klein_round_datapath u_dp (
    .mode      (mode_q),
    .state_in  (data_q),
    .rk        (rk),
    .state_out (rnd_out)
  );

  // Next-state logic: key walk, round counter and handshake flags.
  always_comb begin
    fwd_key     = KEY_W'(key_step(KW_MAX'(key_q), {3'b000, rnd_q}, KEY_W));
    inv_key     = KEY_W'(inv_key_step(KW_MAX'(key_q), {3'b000, rnd_q}, KEY_W));
    rk          = mode_q ? inv_key[KEY_W-1 -: 64] : key_q[KEY_W-1 -: 64];
    state_d     = state_q;
    rnd_d       = rnd_q;
    key_d       = key_q;
    data_d      = data_q;
    mode_d      = mode_q;
    data_out_d  = data_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d     = data_in;
          key_d      = key_in;
          mode_d     = mode;
          rnd_d      = 5'd1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = mode ? ST_KEXP : ST_ROUND;
        end
      end
      ST_KEXP: begin
        // Walk forward to sk_{NR+1}; decryption starts by undoing the whitening.
        key_d = fwd_key;
        if (rnd_q == NR_C) begin
          data_d  = data_q ^ fwd_key[KEY_W-1 -: 64];
          state_d = ST_ROUND;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      ST_ROUND: begin
        data_d = rnd_out;
        if (!mode_q) begin
          key_d = fwd_key;
          if (rnd_q == NR_C) begin
            data_out_d  = rnd_out ^ fwd_key[KEY_W-1 -: 64];
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            rnd_d = rnd_q + 5'd1;
          end
        end else begin
          key_d = inv_key;
          if (rnd_q == 5'd1) begin
            data_out_d  = rnd_out;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            rnd_d = rnd_q - 5'd1;
          end
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rnd_q       <= 5'd0;
      key_q       <= '0;
      data_q      <= 64'd0;
      mode_q      <= 1'b0;
      data_out_q  <= 64'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      key_q       <= key_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_klein_iter_core.sv
// Bench for klein_iter_core: one instance per key width, byte-oriented reference model.
`timescale 1ns/1ps
module tb_klein_iter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid, mode, out_ready;
  wire  [2:0]  in_ready, out_valid, busy;
  logic [63:0] din [3];
  logic [95:0] kin [3];
  wire  [63:0] dout [3];

  int errors = 0;
  int checks = 0;
  logic [63:0] sb [$];

  klein_iter_core #(.KEY_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]),
    .data_in(din[0]), .key_in(kin[0][63:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .data_out(dout[0]), .busy(busy[0]));
  klein_iter_core #(.KEY_W(80)) u80 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]),
    .data_in(din[1]), .key_in(kin[1][79:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .data_out(dout[1]), .busy(busy[1]));
  klein_iter_core #(.KEY_W(96)) u96 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .mode(mode[2]),
    .data_in(din[2]), .key_in(kin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .data_out(dout[2]), .busy(busy[2]));

  localparam logic [63:0] SBOX_TBL = 64'h74A91FB0C3268ED5;

  function automatic int kw_of(input int k);
    return (k == 0) ? 64 : ((k == 1) ? 80 : 96);
  endfunction

  function automatic int nr_w(input int k);
    return (k == 0) ? 12 : ((k == 1) ? 16 : 20);
  endfunction

  function automatic logic [7:0] sbyte(input logic [7:0] b);
    logic [63:0] t;
    t = SBOX_TBL;
    return {t[63-4*b[7:4] -: 4], t[63-4*b[3:0] -: 4]};
  endfunction

  function automatic logic [7:0] x2(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [95:0] rand_key(input int kw);
    logic [95:0] k;
    k = {$urandom, $urandom, $urandom};
    if (kw < 96) k = k & ((96'd1 << kw) - 96'd1);
    return k;
  endfunction

  // Reference KLEIN encryption on byte arrays (byte 0 = most significant).
  function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [95:0] key, input int kw);
    logic [7:0]  kb  [12];
    logic [7:0]  nk  [12];
    logic [7:0]  st  [8];
    logic [7:0]  tmp [8];
    logic [63:0] res;
    int nb, hb, nr;
    nb = kw / 8;
    hb = nb / 2;
    nr = (kw == 64) ? 12 : ((kw == 80) ? 16 : 20);
    for (int j = 0; j < 12; j++) begin kb[j] = 8'h00; nk[j] = 8'h00; end
    for (int j = 0; j < nb; j++) kb[j] = key[kw-1-8*j -: 8];
    for (int j = 0; j < 8; j++) st[j] = pt[63-8*j -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 8; j++) tmp[(j + 6) % 8] = sbyte(st[j] ^ kb[j]);
      for (int h = 0; h < 2; h++)
        for (int m = 0; m < 4; m++)
          st[4*h+m] = x2(tmp[4*h+m]) ^ x2(tmp[4*h+(m+1)%4]) ^ tmp[4*h+(m+1)%4]
                      ^ tmp[4*h+(m+2)%4] ^ tmp[4*h+(m+3)%4];
      for (int j = 0; j < hb; j++) begin
        nk[j]    = kb[hb + (j + 1) % hb];
        nk[hb+j] = kb[(j + 1) % hb] ^ kb[hb + (j + 1) % hb];
      end
      nk[2]    = nk[2] ^ 8'(r);
      nk[hb+1] = sbyte(nk[hb+1]);
      nk[hb+2] = sbyte(nk[hb+2]);
      kb = nk;
    end
    for (int j = 0; j < 8; j++) res[63-8*j -: 8] = st[j] ^ kb[j];
    return res;
  endfunction

  // Push expectation, hand one block to instance k, then pop and compare on out_valid.
  task automatic run_block(input int k, input logic m, input logic [95:0] key,
                           input logic [63:0] d, input logic [63:0] e, input string nm);
    int cyc, lat;
    logic [63:0] exp_v;
    lat = m ? 2 * nr_w(k) : nr_w(k);
    cyc = 0;
    while (in_ready[k] !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (in_ready[k] !== 1'b1) begin
      errors++; $display("FAIL %s_ready: in_ready=%b required 1", nm, in_ready[k]);
    end
    in_valid[k] = 1'b1; mode[k] = m; kin[k] = key; din[k] = d;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid[k] = 1'b0; mode[k] = ~m; kin[k] = {$urandom, $urandom, $urandom}; din[k] = {$urandom, $urandom};
    checks++;
    if (in_ready[k] !== 1'b0 || busy[k] !== 1'b1) begin
      errors++; $display("FAIL %s_busy: in_ready=%b busy=%b required 0/1", nm, in_ready[k], busy[k]);
    end
    cyc = 0;
    while (out_valid[k] !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (cyc !== lat) begin
      errors++; $display("FAIL %s_latency: got %0d cycles required %0d", nm, cyc, lat);
    end
    exp_v = sb.pop_front();
    checks++;
    if (dout[k] !== exp_v) begin
      errors++; $display("FAIL %s_data: data_out=%h required %h", nm, dout[k], exp_v);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || dout[k] !== 64'd0) begin
        errors++;
        $display("FAIL reset_%0d: in_ready=%b out_valid=%b busy=%b data_out=%h required 1/0/0/0",
                 kw_of(k), in_ready[k], out_valid[k], busy[k], dout[k]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
        errors++; $display("FAIL idle_%0d: in_ready=%b busy=%b required 1/0", kw_of(k), in_ready[k], busy[k]);
      end
    end
  endtask

  task automatic test_kat;
    run_block(0, 1'b0, 96'd0, 64'hFFFFFFFFFFFFFFFF, 64'hCDC0B51F14722BBE, "kat_enc");
    run_block(0, 1'b1, 96'd0, 64'hCDC0B51F14722BBE, 64'hFFFFFFFFFFFFFFFF, "kat_dec");
  endtask

  task automatic test_random;
    logic [95:0] key;
    logic [63:0] pt, ct;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < ((k == 0) ? 20 : 100); n++) begin
        key = rand_key(kw_of(k));
        pt  = {$urandom, $urandom};
        ct  = model_enc(pt, key, kw_of(k));
        run_block(k, 1'b0, key, pt, ct, "rand_enc");
        run_block(k, 1'b1, key, ct, pt, "rand_dec");
      end
    end
  endtask

  task automatic test_backpressure;
    logic [95:0] key;
    logic [63:0] pt, exp_v;
    int cyc;
    key = rand_key(64);
    pt  = {$urandom, $urandom};
    out_ready[0] = 1'b0;
    cyc = 0;
    while (in_ready[0] !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    in_valid[0] = 1'b1; mode[0] = 1'b0; kin[0] = key; din[0] = pt;
    sb.push_back(model_enc(pt, key, 64));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    cyc = 0;
    while (out_valid[0] !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    exp_v = sb.pop_front();
    checks++;
    if (out_valid[0] !== 1'b1 || dout[0] !== exp_v) begin
      errors++; $display("FAIL bp_first: out_valid=%b data_out=%h required 1/%h", out_valid[0], dout[0], exp_v);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = c[0]; mode[0] = c[1]; din[0] = {$urandom, $urandom}; kin[0] = rand_key(64);
      @(posedge clk); #1;
      checks++;
      if (dout[0] !== exp_v || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d data_out=%h in_ready=%b out_valid=%b required %h/0/1",
                 c, dout[0], in_ready[0], out_valid[0], exp_v);
      end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid[0], in_ready[0], busy[0]);
    end
    key = rand_key(64);
    pt  = {$urandom, $urandom};
    run_block(0, 1'b0, key, pt, model_enc(pt, key, 64), "bp_next");
  endtask

  task automatic test_back_to_back;
    logic [95:0] key;
    logic [63:0] pts [3];
    int acc_edge [$];
    int sent, got, cyc, gap;
    logic acc;
    logic [63:0] exp_v;
    key = rand_key(64);
    for (int j = 0; j < 3; j++) pts[j] = {$urandom, $urandom};
    sent = 0; got = 0; cyc = 0;
    while (in_ready[0] !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    cyc = 0;
    out_ready[0] = 1'b1; mode[0] = 1'b0; kin[0] = key; din[0] = pts[0]; in_valid[0] = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (out_valid[0] === 1'b1) begin
        exp_v = sb.pop_front();
        got++;
        checks++;
        if (dout[0] !== exp_v) begin
          errors++; $display("FAIL b2b_data: block %0d data_out=%h required %h", got, dout[0], exp_v);
        end
      end
      acc = in_valid[0] && in_ready[0];
      @(posedge clk); cyc++; #1;
      if (acc) begin
        sb.push_back(model_enc(pts[sent], key, 64));
        acc_edge.push_back(cyc);
        sent++;
        if (sent < 3) din[0] = pts[sent];
        else in_valid[0] = 1'b0;
      end
    end
    in_valid[0] = 1'b0;
    checks++;
    if (got !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d blocks required 3", got);
    end
    // Each block occupies NR round cycles, one DONE cycle and one IDLE cycle.
    for (int j = 1; j < acc_edge.size(); j++) begin
      gap = acc_edge[j] - acc_edge[j-1];
      checks++;
      if (gap !== 14) begin
        errors++; $display("FAIL b2b_period: accept spacing %0d required 14", gap);
      end
    end
  endtask

  task automatic test_abort;
    logic [95:0] key;
    logic [63:0] pt;
    int cyc, seen;
    cyc = 0;
    while (in_ready[0] !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    in_valid[0] = 1'b1; mode[0] = 1'b0; kin[0] = rand_key(64); din[0] = {$urandom, $urandom};
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 64'd0) begin
      errors++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b busy=%b data_out=%h required 1/0/0/0",
               in_ready[0], out_valid[0], busy[0], dout[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid[0] !== 1'b0) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_quiet: out_valid high %0d cycles required 0", seen);
    end
    key = rand_key(64);
    pt  = {$urandom, $urandom};
    run_block(0, 1'b0, key, pt, model_enc(pt, key, 64), "abort_next");
    run_block(0, 1'b1, key, model_enc(pt, key, 64), pt, "abort_next_dec");
  endtask

  initial begin
    in_valid  = 3'b000;
    mode      = 3'b000;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin din[k] = 64'd0; kin[k] = 96'd0; end
    rst_n = 1'b0;
    test_reset;
    test_kat;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
